apb_uart_sequencer: RTL and testbench

- Upstream APB master stage that drives the APB request side of the UART subsystem top.
- Turns a byte stream into APB transfers: one config write, then a data write per byte, waiting for each UART Tx to complete.
- On every UART Rx completion it issues an APB read and presents the received byte on a valid-only output.
- Buffers outgoing bytes in an internal FIFO, handles APB errors, and times out stalled transfers.

---
 rtl/apb_uart_sequencer_if.sv | 22 ++
 rtl/apb_uart_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_apb_uart_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_uart_sequencer_if.sv
// APB request/response bundle between the UART sequencer (master) and the UART
// subsystem top (slave).
interface apb_uart_sequencer_if;
  logic        apb_en;
  logic [1:0]  apb_sel;
  logic [4:0]  apb_addr;
  logic        apb_write;
  logic [31:0] apb_wdata;
  logic [31:0] apb_rdata;
  logic        apb_ready;
  logic        apb_error;

  modport master (
    output apb_en, apb_sel, apb_addr, apb_write, apb_wdata,
    input  apb_rdata, apb_ready, apb_error
  );

  modport slave (
    input  apb_en, apb_sel, apb_addr, apb_write, apb_wdata,
    output apb_rdata, apb_ready, apb_error
  );
endinterface

// File: rtl/apb_uart_sequencer.sv
// APB master that feeds a UART: one config write, then one data write per queued
// byte (each waiting for Tx completion), plus an APB read for every Rx completion.
module apb_uart_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [4:0]  ADDR_CFG   = 5'h00,
  parameter logic [4:0]  ADDR_TX    = 5'h04,
  parameter logic [4:0]  ADDR_RX    = 5'h08,
  parameter logic [1:0]  SLV_SEL    = 2'b01,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [1:0]                  cfg_baud,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_update,
  input  logic [7:0]                  tx_byte,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [7:0]                  rx_byte,
  output logic                        rx_valid,
  apb_uart_sequencer_if.master        apb,
  input  logic                        uart_tx_done,
  input  logic                        uart_rx_done,
  output logic                        busy,
  output logic                        err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW:0]   PTR_ONE = 1;
  localparam logic [TW-1:0] TMO_ONE = 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_TX_WR, S_TX_WAIT, S_RX_RD, S_ERR} state_e;

  state_e        state_q, state_d;
  logic          en_q, en_d, write_q, write_d;
  logic [1:0]    sel_q, sel_d;
  logic [4:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          err_q, err_d;
  logic          rx_pend_q, cfg_pend_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          pop, rx_launch, cfg_launch, timed_out, counted;

  // Tx byte FIFO; the extra pointer bit separates full from empty.
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q, rd_ptr_q;
  logic fifo_empty, fifo_full, push;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push       = tx_valid && !fifo_full;

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= tx_byte;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  assign timed_out = (tmo_q == TMO_MAX);
  assign counted   = (state_q == S_CFG) || (state_q == S_TX_WR) ||
                     (state_q == S_RX_RD) || (state_q == S_TX_WAIT);

  // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    err_d      = err_q;
    pop        = 1'b0;
    rx_launch  = 1'b0;
    cfg_launch = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_pend_q) begin
          state_d   = S_RX_RD;
          en_d      = 1'b1;
          sel_d     = SLV_SEL;
          addr_d    = ADDR_RX;
          write_d   = 1'b0;
          wdata_d   = '0;
          rx_launch = 1'b1;
        end else if (cfg_pend_q) begin
          state_d    = S_CFG;
          en_d       = 1'b1;
          sel_d      = SLV_SEL;
          addr_d     = ADDR_CFG;
          write_d    = 1'b1;
          wdata_d    = {28'b0, cfg_parity, cfg_baud};
          cfg_launch = 1'b1;
        end else if (!fifo_empty) begin
          state_d = S_TX_WR;
          en_d    = 1'b1;
          sel_d   = SLV_SEL;
          addr_d  = ADDR_TX;
          write_d = 1'b1;
          wdata_d = {24'b0, mem_q[rd_ptr_q[PW-1:0]]};
        end
      end
      S_CFG, S_TX_WR, S_RX_RD: begin
        if (apb.apb_ready) begin
          en_d  = 1'b0;
          sel_d = 2'b00;
          pop   = (state_q == S_TX_WR);
          if (apb.apb_error) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (state_q == S_TX_WR) begin
            state_d = S_TX_WAIT;
          end else begin
            state_d = S_IDLE;
            if (state_q == S_RX_RD) begin
              rx_valid_d = 1'b1;
              rx_byte_d  = apb.apb_rdata[7:0];
            end
          end
        end else if (timed_out) begin
          en_d    = 1'b0;
          sel_d   = 2'b00;
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_TX_WAIT: begin
        if (uart_tx_done) begin
          state_d = S_IDLE;
        end else if (timed_out) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Restarts on every state entry; only the waiting states accumulate.
    if (state_d != state_q) tmo_d = '0;
    else if (counted)       tmo_d = tmo_q + TMO_ONE;
    else                    tmo_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      sel_q      <= 2'b00;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
      rx_pend_q  <= 1'b0;
      cfg_pend_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
      // A new request in the launch cycle wins over the clear.
      rx_pend_q  <= uart_rx_done || (rx_pend_q && !rx_launch);
      cfg_pend_q <= cfg_update   || (cfg_pend_q && !cfg_launch);
    end
  end

  logic unused_rdata;
  assign unused_rdata = ^apb.apb_rdata[31:8];

  assign apb.apb_en    = en_q;
  assign apb.apb_sel   = sel_q;
  assign apb.apb_addr  = addr_q;
  assign apb.apb_write = write_q;
  assign apb.apb_wdata = wdata_q;
  assign tx_ready      = !fifo_full;
  assign rx_byte       = rx_byte_q;
  assign rx_valid      = rx_valid_q;
  assign err           = err_q;
  assign busy          = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_apb_uart_sequencer.sv
// Scoreboard bench for apb_uart_sequencer: directed stimulus queues expected APB
// launches and Rx bytes; a monitor checks them as the DUT presents them.
module tb_apb_uart_sequencer;

  localparam logic [4:0] ADDR_CFG = 5'h00;
  localparam logic [4:0] ADDR_TX  = 5'h04;
  localparam logic [4:0] ADDR_RX  = 5'h08;
  localparam logic [1:0] SLV_SEL  = 2'b01;

  typedef struct packed {
    logic [4:0]  addr;
    logic        write;
    logic [31:0] wdata;
  } xfer_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] cfg_baud, cfg_parity;
  logic       cfg_update;
  logic [7:0] tx_byte;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       uart_tx_done, uart_rx_done;
  logic       busy, err;

  apb_uart_sequencer_if apb_if ();

  apb_uart_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_baud     (cfg_baud),
    .cfg_parity   (cfg_parity),
    .cfg_update   (cfg_update),
    .tx_byte      (tx_byte),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .apb          (apb_if),
    .uart_tx_done (uart_tx_done),
    .uart_rx_done (uart_rx_done),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  xfer_t      exp_q[$];
  logic [7:0] rx_q[$];

  // Slave model controls
  bit          ack_en = 1'b1;
  int          ack_delay = 2;
  bit          err_once = 1'b0;
  logic [31:0] rdata_val = 32'h0;
  bit          tx_outstanding = 1'b0;
  int          wait_cnt = 0;
  int          tx_cnt = 0;
  bit          allow_drop = 1'b0;

  // Monitor history
  logic        prev_en, prev_ready, prev_write, prev_rxv;
  logic [4:0]  prev_addr;
  logic [31:0] prev_wdata;
  xfer_t       mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_byte  = b;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0 || busy || tx_outstanding) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 64'(n < budget), 64'd1);
  endtask

  // APB slave + UART Tx model: acks after ack_delay cycles, signals tx_done 20 cycles after a Tx write.
  initial begin
    apb_if.apb_ready = 1'b0;
    apb_if.apb_error = 1'b0;
    apb_if.apb_rdata = 32'h0;
    uart_tx_done     = 1'b0;
    forever begin
      @(posedge clk); #1;
      apb_if.apb_ready = 1'b0;
      apb_if.apb_error = 1'b0;
      uart_tx_done     = 1'b0;
      if (!reset_n) begin
        wait_cnt = 0;
        tx_cnt = 0;
        tx_outstanding = 1'b0;
        continue;
      end
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          uart_tx_done   = 1'b1;
          tx_outstanding = 1'b0;
        end
      end
      if (apb_if.apb_en && ack_en) begin
        if (wait_cnt == ack_delay) begin
          apb_if.apb_ready = 1'b1;
          apb_if.apb_error = err_once;
          apb_if.apb_rdata = rdata_val;
          if (apb_if.apb_write && apb_if.apb_addr == ADDR_TX && !err_once) begin
            tx_cnt = 20;
            tx_outstanding = 1'b1;
          end
          err_once = 1'b0;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compares launches and Rx strobes against the scoreboard queues.
  initial begin
    prev_en = 1'b0; prev_ready = 1'b0; prev_rxv = 1'b0;
    prev_write = 1'b0; prev_addr = '0; prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_en = 1'b0; prev_ready = 1'b0; prev_rxv = 1'b0;
        continue;
      end
      if (apb_if.apb_en && !prev_en) begin
        check("launch_sel", 64'(apb_if.apb_sel), 64'(SLV_SEL));
        check("launch_after_tx_done", 64'(tx_outstanding), 64'd0);
        check("xfer_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("xfer_addr", 64'(apb_if.apb_addr), 64'(mon_e.addr));
          check("xfer_write", 64'(apb_if.apb_write), 64'(mon_e.write));
          if (mon_e.write) check("xfer_wdata", 64'(apb_if.apb_wdata), 64'(mon_e.wdata));
        end
      end
      if (prev_en && prev_ready) begin
        check("release", 64'({apb_if.apb_en, apb_if.apb_sel}), 64'd0);
      end else if (prev_en && !allow_drop) begin
        check("hold", 64'({apb_if.apb_en, apb_if.apb_addr, apb_if.apb_write, apb_if.apb_wdata}),
              64'({1'b1, prev_addr, prev_write, prev_wdata}));
      end
      if (rx_valid) begin
        check("rx_strobe_width", 64'(prev_rxv), 64'd0);
        check("rx_expected", 64'(rx_q.size() != 0), 64'd1);
        if (rx_q.size() != 0) check("rx_byte", 64'(rx_byte), 64'(rx_q.pop_front()));
      end
      prev_en    = apb_if.apb_en;
      prev_ready = apb_if.apb_ready;
      prev_addr  = apb_if.apb_addr;
      prev_write = apb_if.apb_write;
      prev_wdata = apb_if.apb_wdata;
      prev_rxv   = rx_valid;
    end
  end

  initial begin
    int n;
    reset_n = 1'b1;
    cfg_baud = 2'd2; cfg_parity = 2'd1; cfg_update = 1'b0;
    tx_byte = 8'h00; tx_valid = 1'b0; uart_rx_done = 1'b0;
    #2 reset_n = 1'b0;
    cycles(3);

    // Reset state
    check("reset_tx_ready", 64'(tx_ready), 64'd1);
    check("reset_outputs", 64'({apb_if.apb_en, apb_if.apb_sel, apb_if.apb_addr, apb_if.apb_write,
                                rx_valid, rx_byte, busy, err}), 64'd0);
    check("reset_wdata", 64'(apb_if.apb_wdata), 64'd0);

    // First transfer is the config write: {parity=1, baud=2} -> 0x6
    exp_q.push_back('{ADDR_CFG, 1'b1, 32'h6});
    reset_n = 1'b1;
    wait_drain("cfg_after_reset", 50);

    // Two bytes, second only after the first tx_done
    exp_q.push_back('{ADDR_TX, 1'b1, 32'h55});
    exp_q.push_back('{ADDR_TX, 1'b1, 32'hA3});
    push_byte(8'h55);
    push_byte(8'hA3);
    wait_drain("tx_two_bytes", 200);

    // Rx completion during TX_WAIT -> read issued after tx_done
    rdata_val = 32'h000000C3;
    exp_q.push_back('{ADDR_TX, 1'b1, 32'h11});
    push_byte(8'h11);
    n = 0;
    while (!tx_outstanding && n < 30) begin cycles(1); n++; end
    check("tx_wait_reached", 64'(tx_outstanding), 64'd1);
    cycles(3);
    check("busy_in_tx_wait", 64'(busy), 64'd1);
    exp_q.push_back('{ADDR_RX, 1'b0, 32'h0});
    rx_q.push_back(8'hC3);
    uart_rx_done = 1'b1;
    cycles(1);
    uart_rx_done = 1'b0;
    wait_drain("rx_read", 100);
    check("rx_byte_held", 64'(rx_byte), 64'hC3);

    // cfg_update re-issues the config write with new fields {0,3} -> 0x3
    cfg_baud = 2'd3; cfg_parity = 2'd0;
    exp_q.push_back('{ADDR_CFG, 1'b1, 32'h3});
    cfg_update = 1'b1;
    cycles(1);
    cfg_update = 1'b0;
    wait_drain("cfg_update", 50);

    // Error on a Tx write: byte dropped, no TX_WAIT, next byte follows promptly
    check("err_clear_before", 64'(err), 64'd0);
    err_once = 1'b1;
    exp_q.push_back('{ADDR_TX, 1'b1, 32'h77});
    exp_q.push_back('{ADDR_TX, 1'b1, 32'h88});
    push_byte(8'h77);
    push_byte(8'h88);
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin cycles(1); n++; end
    check("next_byte_after_error", 64'(n < 30), 64'd1);
    check("err_sticky", 64'(err), 64'd1);
    wait_drain("error_drain", 100);
    check("err_still_set", 64'(err), 64'd1);

    // Reset mid-transfer
    ack_en = 1'b0;
    exp_q.push_back('{ADDR_TX, 1'b1, 32'h5A});
    push_byte(8'h5A);
    n = 0;
    while (!apb_if.apb_en && n < 20) begin cycles(1); n++; end
    check("midxfer_en_up", 64'(apb_if.apb_en), 64'd1);
    cycles(2);
    reset_n = 1'b0;
    #1;
    check("async_reset_en", 64'({apb_if.apb_en, apb_if.apb_sel}), 64'd0);
    exp_q.delete();
    cycles(2);
    check("reset_clears_err", 64'(err), 64'd0);
    check("reset_empties_fifo", 64'({tx_ready, busy}), 64'b10);
    ack_en = 1'b1;
    cfg_baud = 2'd1; cfg_parity = 2'd3;
    exp_q.push_back('{ADDR_CFG, 1'b1, 32'hD});
    reset_n = 1'b1;
    wait_drain("cfg_first_after_reset", 50);

    // Fill FIFO with no ack; timeout leaves the head in place and retries it
    ack_en = 1'b0;
    allow_drop = 1'b1;
    exp_q.push_back('{ADDR_TX, 1'b1, 32'h01});
    exp_q.push_back('{ADDR_TX, 1'b1, 32'h01});
    for (int i = 2; i <= 8; i++) exp_q.push_back('{ADDR_TX, 1'b1, 32'(i)});
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    check("fifo_full_tx_ready", 64'(tx_ready), 64'd0);
    cycles(100);
    check("no_early_timeout", 64'(err), 64'd0);
    n = 0;
    while (!err && n < 400) begin cycles(1); n++; end
    check("timeout_err", 64'(err), 64'd1);
    check("timeout_head_kept", 64'({tx_ready, busy}), 64'b01);
    ack_en = 1'b1;
    cycles(2);
    allow_drop = 1'b0;
    wait_drain("drain_after_timeout", 800);

    check("scoreboard_empty", 64'(exp_q.size() + rx_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
